alu_serial: RTL and testbench
=============================

// Module: alu_serial
// PURPOSE
//  Multi-cycle, digit-serial ALU. Processes a WIDTH-bit operation SLICE bits per cycle over
//  WIDTH/SLICE cycles, with a start/done handshake. Supports AND/OR/ADD(SUB) and six compare modes.
//  Replaces the fully-unrolled bit-slice ALU where area matters more than latency (multi-cycle datapath).
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of SLICE
//  SLICE   8  bits processed per cycle; 1..WIDTH. NSLICE = WIDTH/SLICE
// PORTS
//  clk_i       in   1      clock; all state on rising edge
//  rst_i       in   1      reset, asynchronous, active-low
//  start_i     in   1      request; sampled only in IDLE or DONE
//  src1_i      in   WIDTH  operand A, captured on accepted start
//  src2_i      in   WIDTH  operand B, captured on accepted start
//  a_inv_i     in   1      invert A (ignored for op 11)
//  b_inv_i     in   1      invert B; also the initial carry-in (ignored for op 11)
//  op_i        in   2      00 AND, 01 OR, 10 ADD, 11 COMPARE
//  cmp_i       in   3      compare mode: 000 lt, 001 gt, 010 le, 011 ge, 110 eq, 100 ne; others -> 0
//  busy_o      out  1      high while in RUN
//  done_o      out  1      one-cycle pulse; results valid from this cycle
//  result_o    out  WIDTH  result; held until the next accepted start
//  zero_o      out  1      result_o == 0
//  cout_o      out  1      carry out of MSB (ADD/COMPARE), 0 for AND/OR
//  overflow_o  out  1      signed overflow (ADD/COMPARE), 0 for AND/OR
// BEHAVIOUR
//  - Reset (async, rst_i=0): state IDLE, all outputs 0, slice counter 0, carry 0, operand regs 0.
//  - FSM IDLE -> RUN on start_i. RUN -> DONE after NSLICE slice cycles. DONE -> IDLE after 1 cycle,
//    or DONE -> RUN directly if start_i is high in DONE (back-to-back ops).
//  - start_i while in RUN is ignored; captured operands and control are unaffected by input changes.
//  - Accepted start (cycle 0): latch src1/src2/ctrl. carry <= b_inv_i (1 for op 11). counter <= 0.
//    busy_o is 1 in cycles 1..NSLICE. done_o is 1 in cycle NSLICE+1. Latency = NSLICE+1 cycles.
//  - RUN cycle k (k = 0..NSLICE-1): bits [k*SLICE +: SLICE] go through alu_slice; carry is
//    registered between slices; result slice is written into the result shift register.
//  - op 11 forces A'=A, B'=~B, cin=1 (A-B). less = sum[MSB] ^ overflow (signed);
//    equal = (A-B)==0. Per cmp_i: lt=less, gt=~less&~equal, le=less|equal, ge=~less|equal,
//    eq=equal, ne=~equal. result_o = {WIDTH-1 zeros, cmp_bit}.
//  - overflow = carry into MSB ^ carry out of MSB, on the final slice only.
//  - Reserved cmp_i codes (101, 111) yield result_o = 0, zero_o = 1; not an error.
//  - result_o/zero_o/cout_o/overflow_o update together in the DONE cycle and hold stable until
//    the DONE cycle of the next operation; intermediate slices are never visible on result_o.
//  - Reset asserted mid-RUN aborts the op: no done_o pulse, outputs return to 0.
//  - NSLICE=1 (SLICE=WIDTH): one RUN cycle, latency 2. Counter width max(1, $clog2(NSLICE)).
// STRUCTURE
//  - Package alu_pkg: op encodings (OP_AND/OP_OR/OP_ADD/OP_CMP), compare codes (CMP_LT..CMP_NE),
//    FSM state enum (S_IDLE/S_RUN/S_DONE).
//  - Sub-module alu_slice (param SLICE): combinational SLICE-bit AND/OR/ADD with a_inv/b_inv/cin,
//    outputs result slice, cout, carry into its MSB. Instantiated once; top holds FSM, counter,
//    operand/result shift registers, carry register and compare logic.
// TESTING (WIDTH=32, SLICE=8 unless noted)
//  1. Reset mid-op: start ADD, assert rst_i=0 in RUN cycle 2 -> all outputs 0, no done_o, back to IDLE.
//  2. ADD 0x7FFFFFFF+0x00000001 -> done_o at cycle 5, result 0x80000000, overflow 1, cout 0, zero 0.
//  3. SUB (op 10, b_inv=1) 5-5 -> result 0, zero_o 1, cout_o 1; AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000.
//  4. COMPARE A=-1 (0xFFFFFFFF), B=1, all six modes -> lt 1, gt 0, le 1, ge 0, eq 0, ne 1;
//     A=B=0x80000000 -> eq 1, le 1, ge 1, lt 0; cmp_i=101 -> result 0.
//  5. Back-to-back: start held high through DONE -> second op enters RUN with no IDLE cycle;
//     start pulsed in RUN -> ignored; operands changed during RUN -> no effect on result.
//  6. SLICE=32 and SLICE=1 builds: ADD 0x12345678+0x11111111 = 0x23456789, latency 2 and 33.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the digit-serial ALU: opcodes, compare modes, FSM states
// and the compare-mode decode.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    localparam logic [2:0] CMP_LT = 3'b000;
    localparam logic [2:0] CMP_GT = 3'b001;
    localparam logic [2:0] CMP_LE = 3'b010;
    localparam logic [2:0] CMP_GE = 3'b011;
    localparam logic [2:0] CMP_EQ = 3'b110;
    localparam logic [2:0] CMP_NE = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Reserved codes (101, 111) evaluate to 0.
    function automatic logic cmp_eval(input logic [2:0] cmp, input logic less,
                                      input logic equal);
        logic r;
        case (cmp)
            CMP_LT:  r = less;
            CMP_GT:  r = ~less & ~equal;
            CMP_LE:  r = less | equal;
            CMP_GE:  r = ~less | equal;
            CMP_EQ:  r = equal;
            CMP_NE:  r = ~equal;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit AND/OR/ADD stage with operand inversion and carry-in.
// Also reports the carry into its MSB so the caller can form signed overflow.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             a_inv_i,
    input  logic             b_inv_i,
    input  logic             cin_i,
    input  logic [1:0]       op_i,
    output logic [SLICE-1:0] res_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE-1:0] a_m;
    logic [SLICE-1:0] b_m;
    logic [SLICE:0]   sum;

    assign a_m = a_inv_i ? ~a_i : a_i;
    assign b_m = b_inv_i ? ~b_i : b_i;
    assign sum = {1'b0, a_m} + {1'b0, b_m} + {{SLICE{1'b0}}, cin_i};

    assign cout_o = sum[SLICE];
    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out without a second adder.
    assign cmsb_o = sum[SLICE-1] ^ a_m[SLICE-1] ^ b_m[SLICE-1];

    always_comb begin
        res_o = sum[SLICE-1:0];
        case (op_i)
            OP_AND:  res_o = a_m & b_m;
            OP_OR:   res_o = a_m | b_m;
            default: res_o = sum[SLICE-1:0];
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: one SLICE-bit chunk per cycle over WIDTH/SLICE cycles, with a
// start/done handshake. Results only change in the DONE cycle.
module alu_serial
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             a_inv_i,
    input  logic             b_inv_i,
    input  logic [1:0]       op_i,
    input  logic [2:0]       cmp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [1:0]       op_q;
    logic [2:0]       cmp_q;
    logic             a_inv_q, b_inv_q, carry_q, nz_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, cout_q, ovf_q;

    logic             accept, last;
    logic [SLICE-1:0] s_res;
    logic             s_cout, s_cmsb;
    logic [WIDTH-1:0] acc_next, res_final;
    logic             ovf, less, equal, arith;

    assign accept = start_i && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start_i ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Compare is a subtract; its forced inversion/carry are applied when operands are captured.
    alu_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a_i     (a_q[SLICE-1:0]),
        .b_i     (b_q[SLICE-1:0]),
        .a_inv_i (a_inv_q),
        .b_inv_i (b_inv_q),
        .cin_i   (carry_q),
        .op_i    ((op_q == OP_CMP) ? OP_ADD : op_q),
        .res_o   (s_res),
        .cout_o  (s_cout),
        .cmsb_o  (s_cmsb)
    );

    always_comb begin
        acc_next  = (acc_q >> SLICE) | (WIDTH'(s_res) << (WIDTH - SLICE));
        ovf       = s_cmsb ^ s_cout;
        less      = s_res[SLICE-1] ^ ovf;
        equal     = ~(nz_q | (|s_res));
        arith     = op_q[1];
        res_final = acc_next;
        if (op_q == OP_CMP) res_final = WIDTH'(cmp_eval(cmp_q, less, equal));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            cmp_q    <= '0;
            a_inv_q  <= 1'b0;
            b_inv_q  <= 1'b0;
            carry_q  <= 1'b0;
            nz_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= src1_i;
                b_q     <= src2_i;
                op_q    <= op_i;
                cmp_q   <= cmp_i;
                a_inv_q <= (op_i == OP_CMP) ? 1'b0 : a_inv_i;
                b_inv_q <= (op_i == OP_CMP) ? 1'b1 : b_inv_i;
                carry_q <= (op_i == OP_CMP) ? 1'b1 : b_inv_i;
                cnt_q   <= '0;
                nz_q    <= 1'b0;
            end else if (state_q == S_RUN) begin
                a_q     <= a_q >> SLICE;
                b_q     <= b_q >> SLICE;
                acc_q   <= acc_next;
                carry_q <= s_cout;
                nz_q    <= nz_q | (|s_res);
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last) begin
                    result_q <= res_final;
                    zero_q   <= (res_final == '0);
                    cout_q   <= arith & s_cout;
                    ovf_q    <= arith & ovf;
                end
            end
        end
    end

    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: SLICE=8, SLICE=32 and SLICE=1 instances checked against an
// arithmetic reference model, plus directed corner cases and handshake scenarios.
module tb_alu_serial;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start32, start1;
    logic [31:0] src1, src2;
    logic        a_inv, b_inv;
    logic [1:0]  op;
    logic [2:0]  cmp;

    logic        busy8, done8, zero8, cout8, ovf8;
    logic        busy32, done32, zero32, cout32, ovf32;
    logic        busy1, done1, zero1, cout1, ovf1;
    logic [31:0] res8, res32, res1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(32), .SLICE(8)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start8), .src1_i(src1), .src2_i(src2),
        .a_inv_i(a_inv), .b_inv_i(b_inv), .op_i(op), .cmp_i(cmp), .busy_o(busy8),
        .done_o(done8), .result_o(res8), .zero_o(zero8), .cout_o(cout8), .overflow_o(ovf8)
    );

    alu_serial #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start32), .src1_i(src1), .src2_i(src2),
        .a_inv_i(a_inv), .b_inv_i(b_inv), .op_i(op), .cmp_i(cmp), .busy_o(busy32),
        .done_o(done32), .result_o(res32), .zero_o(zero32), .cout_o(cout32), .overflow_o(ovf32)
    );

    alu_serial #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start1), .src1_i(src1), .src2_i(src2),
        .a_inv_i(a_inv), .b_inv_i(b_inv), .op_i(op), .cmp_i(cmp), .busy_o(busy1),
        .done_o(done1), .result_o(res1), .zero_o(zero1), .cout_o(cout1), .overflow_o(ovf1)
    );

    // Reference model: whole-word arithmetic, signed ranges via 64-bit integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ai,
                                   input logic bi, input logic [1:0] o, input logic [2:0] c);
        exp_t        e;
        logic [31:0] x, y;
        logic        ci, less, eq, bit_v;
        logic [32:0] s;
        longint      ss;
        x = ai ? ~a : a;
        y = bi ? ~b : b;
        ci = bi;
        e.cout = 1'b0;
        e.ovf  = 1'b0;
        bit_v  = 1'b0;
        case (o)
            2'b00: e.res = x & y;
            2'b01: e.res = x | y;
            2'b10: begin
                s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
                e.res = s[31:0];
                e.cout = s[32];
                ss = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
                e.ovf = (ss != longint'($signed(e.res)));
            end
            default: begin
                less = $signed(a) < $signed(b);
                eq   = (a == b);
                case (c)
                    3'b000: bit_v = less;
                    3'b001: bit_v = !less && !eq;
                    3'b010: bit_v = less || eq;
                    3'b011: bit_v = !less;
                    3'b110: bit_v = eq;
                    3'b100: bit_v = !eq;
                    default: bit_v = 1'b0;
                endcase
                e.res  = {31'd0, bit_v};
                e.cout = (a >= b);
                ss = longint'($signed(a)) - longint'($signed(b));
                e.ovf = (ss != longint'($signed(a - b)));
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start8 = v;
            1: start32 = v;
            default: start1 = v;
        endcase
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done8;
            1: return done32;
            default: return done1;
        endcase
    endfunction

    function automatic exp_t out_of(input int sel);
        case (sel)
            0: return {res8, zero8, cout8, ovf8};
            1: return {res32, zero32, cout32, ovf32};
            default: return {res1, zero1, cout1, ovf1};
        endcase
    endfunction

    // Launch one op; lat counts cycles from the accepting edge to the first cycle with done.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic ai, input logic bi, input logic [1:0] o,
                          input logic [2:0] c, output exp_t got, output int lat);
        @(negedge clk);
        src1 = a; src2 = b; a_inv = ai; b_inv = bi; op = o; cmp = c;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        lat = 1;
        while (!done_of(sel) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = out_of(sel);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 0; start32 = 0; start1 = 0;
        src1 = '0; src2 = '0; a_inv = 0; b_inv = 0; op = '0; cmp = '0;
        #12;
        total++;
        if ({busy8, done8, res8, zero8, cout8, ovf8} !== 36'd0) begin
            bad++;
            $display("FAIL reset8: got %h required 0", {busy8, done8, res8, zero8, cout8, ovf8});
        end
        total++;
        if ({busy32, done32, res32, zero32, cout32, ovf32, busy1, done1, res1, zero1, cout1, ovf1}
            !== 72'd0) begin
            bad++;
            $display("FAIL reset32_1: outputs not all zero in reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        exp_t got, e;
        int   lat;
        run_op(0, 32'h7FFFFFFF, 32'h00000001, 0, 0, 2'b10, 3'b000, got, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL add_latency: got %0d required 5", lat); end
        total++;
        if (got !== {32'h80000000, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_ovf: got %h required %h", got, {32'h80000000, 3'b001});
        end
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            logic [1:0]  o;
            logic [2:0]  c;
            logic        ai, bi;
            a  = $urandom;
            b  = (i % 5 == 0) ? a : $urandom;
            o  = 2'($urandom_range(0, 3));
            c  = 3'($urandom_range(0, 7));
            ai = 1'($urandom_range(0, 1));
            bi = 1'($urandom_range(0, 1));
            e  = model(a, b, ai, bi, o, c);
            run_op(0, a, b, ai, bi, o, c, got, lat);
            total++;
            if (got !== e || lat !== 5) begin
                bad++;
                $display("FAIL rand8[%0d] op=%0d cmp=%0d: got %h lat %0d required %h lat 5",
                         i, o, c, got, lat, e);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic seen;
        @(negedge clk);
        src1 = 32'h11111111; src2 = 32'h22222222; a_inv = 0; b_inv = 0; op = 2'b10;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy8, done8, res8, zero8, cout8, ovf8} !== 36'd0) begin
            bad++;
            $display("FAIL reset_mid: got %h required 0", {busy8, done8, res8, zero8, cout8, ovf8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: got busy/done activity %b required 0", seen);
        end
    endtask

    task automatic test_sub_and;
        exp_t got;
        int   lat;
        run_op(0, 32'd5, 32'd5, 0, 1, 2'b10, 3'b000, got, lat);
        total++;
        if (got !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_zero: got %h required %h", got, {32'd0, 3'b110});
        end
        run_op(0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 2'b00, 3'b000, got, lat);
        total++;
        if (got !== {32'hF000F000, 3'b000}) begin
            bad++;
            $display("FAIL and: got %h required %h", got, {32'hF000F000, 3'b000});
        end
    endtask

    task automatic test_compare;
        exp_t        got;
        int          lat;
        logic [2:0]  modes [6];
        logic        want1 [6];
        logic        want2 [6];
        modes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
        want1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        want2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(0, 32'hFFFFFFFF, 32'd1, 1, 0, 2'b11, modes[i], got, lat);
            total++;
            if (got.res !== {31'd0, want1[i]} || got.zero !== !want1[i]) begin
                bad++;
                $display("FAIL cmp_m1_1 mode %b: got %h required %0d", modes[i], got, want1[i]);
            end
            run_op(0, 32'h80000000, 32'h80000000, 0, 1, 2'b11, modes[i], got, lat);
            total++;
            if (got.res !== {31'd0, want2[i]}) begin
                bad++;
                $display("FAIL cmp_eq mode %b: got %h required %0d", modes[i], got.res, want2[i]);
            end
        end
        run_op(0, 32'd3, 32'd9, 0, 0, 2'b11, 3'b101, got, lat);
        total++;
        if (got.res !== 32'd0 || got.zero !== 1'b1) begin
            bad++;
            $display("FAIL cmp_reserved: got %h required res 0 zero 1", got);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e1, e2, got;
        int   lat;
        e1 = model(32'h01020304, 32'h10203040, 0, 0, 2'b10, 3'b000);
        e2 = model(32'hCAFE0000, 32'h0000BABE, 0, 0, 2'b01, 3'b000);
        @(negedge clk);
        src1 = 32'h01020304; src2 = 32'h10203040; a_inv = 0; b_inv = 0; op = 2'b10;
        start8 = 1'b1;
        @(posedge clk); #1;
        // Second op's operands go in now; start stays high through RUN and into DONE.
        src1 = 32'hCAFE0000; src2 = 32'h0000BABE; op = 2'b01;
        lat = 1;
        while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
        total++;
        if ({res8, zero8, cout8, ovf8} !== e1 || lat !== 5) begin
            bad++;
            $display("FAIL b2b_first: got %h lat %0d required %h lat 5",
                     {res8, zero8, cout8, ovf8}, lat, e1);
        end
        @(posedge clk); #1;
        total++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || res8 !== e1.res) begin
            bad++;
            $display("FAIL b2b_direct: got busy %b done %b res %h required 1 0 %h",
                     busy8, done8, res8, e1.res);
        end
        lat = 1;
        while (!done8 && lat < 100) begin
            start8 = (lat == 2);
            src1 = $urandom; src2 = $urandom; op = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        total++;
        if ({res8, zero8, cout8, ovf8} !== e2 || lat !== 5) begin
            bad++;
            $display("FAIL b2b_second: got %h lat %0d required %h lat 5",
                     {res8, zero8, cout8, ovf8}, lat, e2);
        end
        @(posedge clk); #1;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ignored_start: got busy %b done %b required 0 0", busy8, done8);
        end
    endtask

    task automatic test_slice_builds;
        exp_t got, e;
        int   lat;
        int   want_lat [3];
        want_lat = '{5, 2, 33};
        for (int sel = 1; sel < 3; sel++) begin
            run_op(sel, 32'h12345678, 32'h11111111, 0, 0, 2'b10, 3'b000, got, lat);
            total++;
            if (got.res !== 32'h23456789 || lat !== want_lat[sel]) begin
                bad++;
                $display("FAIL slice_add sel %0d: got %h lat %0d required 23456789 lat %0d",
                         sel, got.res, lat, want_lat[sel]);
            end
            for (int i = 0; i < 6; i++) begin
                logic [31:0] a, b;
                logic [1:0]  o;
                logic [2:0]  c;
                logic        ai, bi;
                a  = $urandom;
                b  = (i == 0) ? a : $urandom;
                o  = 2'($urandom_range(0, 3));
                c  = 3'($urandom_range(0, 7));
                ai = 1'($urandom_range(0, 1));
                bi = 1'($urandom_range(0, 1));
                e  = model(a, b, ai, bi, o, c);
                run_op(sel, a, b, ai, bi, o, c, got, lat);
                total++;
                if (got !== e || lat !== want_lat[sel]) begin
                    bad++;
                    $display("FAIL slice_rand sel %0d op=%0d: got %h lat %0d required %h lat %0d",
                             sel, o, got, lat, e, want_lat[sel]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_reset_mid_op;
        test_sub_and;
        test_compare;
        test_back_to_back;
        test_slice_builds;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
